// File: rtl/sddr_dev_model.sv
// sddr_dev_model: cycle-level DDR3 device responder for sddr_ctrl benches.
// Decodes commands, tracks open banks, stores BL8 words, replays reads after CL, captures writes after CWL.
module sddr_dev_model #(
    parameter int BANK_BITS    = 3,
    parameter int ADDR_BITS    = 14,
    parameter int DATA_BITS    = 16,
    parameter int MEM_ROW_BITS = 1,
    parameter int T_RCD        = 5
) (
    input  logic                          ddr_clock_i,
    input  logic                          ddr_reset_n_i,
    input  logic                          ddr3_cke_i,
    input  logic                          ddr3_cs_n_i,
    input  logic                          ddr3_ras_n_i,
    input  logic                          ddr3_cas_n_i,
    input  logic                          ddr3_we_n_i,
    input  logic [BANK_BITS-1:0]          ddr3_ba_i,
    input  logic [ADDR_BITS-1:0]          ddr3_addr_i,
    input  logic [DATA_BITS/8-1:0]        ddr3_dm_i,
    input  logic                          ddr3_dq_enable_i,
    input  logic [1:0][DATA_BITS-1:0]     ddr3_dq_i,
    output logic [1:0][DATA_BITS-1:0]     ddr3_dq_o,
    output logic                          dq_valid_o,
    output logic                          err_o,
    output logic [3:0]                    err_code_o
);
    localparam int NB    = 1 << BANK_BITS;
    localparam int NBYTE = DATA_BITS / 8;
    localparam int IDX_W = BANK_BITS + MEM_ROW_BITS + 7;
    localparam int RCD_W = (T_RCD > 1) ? $clog2(T_RCD) : 1;
    localparam int CW    = 5;

    typedef logic [7:0][DATA_BITS-1:0] word_t;
    typedef logic [7:0][NBYTE-1:0]     mask_t;

    word_t r_mem [1 << IDX_W];

    logic [NB-1:0]           r_open;
    logic [MEM_ROW_BITS-1:0] r_row [NB];
    logic [RCD_W-1:0]        r_rcd [NB];
    logic [CW-1:0]           r_cl, r_cwl;

    logic                 r_rd_busy, r_rd_ap;
    logic [CW-1:0]        r_rd_cnt, r_rd_cl;
    logic [BANK_BITS-1:0] r_rd_bank;
    word_t                r_rd_word;

    logic                 r_wr_busy, r_wr_ap;
    logic [CW-1:0]        r_wr_cnt, r_wr_cwl;
    logic [BANK_BITS-1:0] r_wr_bank;
    logic [IDX_W-1:0]     r_wr_idx;
    word_t                r_wr_data;
    mask_t                r_wr_dm;

    logic [3:0]       w_cmd, w_cmd_code;
    logic             w_act, w_rd, w_wr, w_pre, w_ref, w_mrs, w_cmd_ok, w_beat_err;
    logic [IDX_W-1:0] w_idx;
    logic [CW-1:0]    w_rd_off, w_wr_off;
    logic             w_rd_beat, w_rd_done, w_wr_beat, w_wr_done;
    word_t            w_wr_full, w_merged;
    mask_t            w_wr_fdm;
    logic             w_unused_addr;

    assign w_cmd = {ddr3_cs_n_i, ddr3_ras_n_i, ddr3_cas_n_i, ddr3_we_n_i};
    assign w_act = ddr3_cke_i && (w_cmd == 4'b0011);
    assign w_rd  = ddr3_cke_i && (w_cmd == 4'b0101);
    assign w_wr  = ddr3_cke_i && (w_cmd == 4'b0100);
    assign w_pre = ddr3_cke_i && (w_cmd == 4'b0010);
    assign w_ref = ddr3_cke_i && (w_cmd == 4'b0001);
    assign w_mrs = ddr3_cke_i && (w_cmd == 4'b0000);
    assign w_unused_addr = ^ddr3_addr_i;

    assign w_idx = {ddr3_ba_i, r_row[ddr3_ba_i], ddr3_addr_i[9:3]};

    // Read beats are presented one cycle early so the controller samples them at N+CL..N+CL+3.
    assign w_rd_off  = r_rd_cnt - (r_rd_cl - CW'(1));
    assign w_rd_beat = r_rd_busy && (r_rd_cnt >= r_rd_cl - CW'(1)) && (r_rd_cnt <= r_rd_cl + CW'(2));
    assign w_rd_done = r_rd_busy && (r_rd_cnt == r_rd_cl + CW'(3));
    assign w_wr_off  = r_wr_cnt - r_wr_cwl;
    assign w_wr_beat = r_wr_busy && (r_wr_cnt >= r_wr_cwl) && (r_wr_cnt <= r_wr_cwl + CW'(3));
    assign w_wr_done = r_wr_busy && (r_wr_cnt == r_wr_cwl + CW'(3));
    assign w_beat_err = w_wr_beat && !ddr3_dq_enable_i;

    always_comb begin
        w_cmd_code = 4'd0;
        if (w_act && r_open[ddr3_ba_i])                             w_cmd_code = 4'd1;
        else if ((w_rd || w_wr) && !r_open[ddr3_ba_i])              w_cmd_code = 4'd2;
        else if ((w_rd || w_wr) && (r_rcd[ddr3_ba_i] != '0))        w_cmd_code = 4'd3;
        else if (w_ref && (|r_open))                                w_cmd_code = 4'd4;
        else if ((w_rd && r_rd_busy) || (w_wr && r_wr_busy))        w_cmd_code = 4'd5;
        else if (w_mrs && (ddr3_ba_i == '0) && (ddr3_addr_i[6:4] == 3'd0)) w_cmd_code = 4'd7;
    end
    assign w_cmd_ok = (w_cmd_code == 4'd0);

    // Last beat pair is folded in combinationally so the whole word commits on that edge.
    always_comb begin
        w_wr_full = r_wr_data;
        w_wr_fdm  = r_wr_dm;
        w_wr_full[{w_wr_off[1:0], 1'b0}] = ddr3_dq_i[0];
        w_wr_full[{w_wr_off[1:0], 1'b1}] = ddr3_dq_i[1];
        w_wr_fdm[{w_wr_off[1:0], 1'b0}]  = ddr3_dm_i;
        w_wr_fdm[{w_wr_off[1:0], 1'b1}]  = ddr3_dm_i;
        w_merged = r_mem[r_wr_idx];
        for (int b = 0; b < 8; b++)
            for (int y = 0; y < NBYTE; y++)
                if (!w_wr_fdm[b][y]) w_merged[b][y*8 +: 8] = w_wr_full[b][y*8 +: 8];
    end

    always_ff @(posedge ddr_clock_i)
        if (w_wr_done) r_mem[r_wr_idx] <= w_merged;

    always_ff @(posedge ddr_clock_i or negedge ddr_reset_n_i) begin
        if (!ddr_reset_n_i) begin
            ddr3_dq_o  <= '0;
            dq_valid_o <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= 4'd0;
            r_open     <= '0;
            for (int b = 0; b < NB; b++) begin
                r_row[b] <= '0;
                r_rcd[b] <= '0;
            end
            r_cl      <= CW'(5);
            r_cwl     <= CW'(5);
            r_rd_busy <= 1'b0;
            r_rd_ap   <= 1'b0;
            r_rd_cnt  <= '0;
            r_rd_cl   <= '0;
            r_rd_bank <= '0;
            r_rd_word <= '0;
            r_wr_busy <= 1'b0;
            r_wr_ap   <= 1'b0;
            r_wr_cnt  <= '0;
            r_wr_cwl  <= '0;
            r_wr_bank <= '0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
            r_wr_dm   <= '0;
        end else begin
            if (!err_o && !w_cmd_ok) begin
                err_o      <= 1'b1;
                err_code_o <= w_cmd_code;
            end else if (!err_o && w_beat_err) begin
                err_o      <= 1'b1;
                err_code_o <= 4'd6;
            end
            for (int b = 0; b < NB; b++)
                if (r_rcd[b] != '0) r_rcd[b] <= r_rcd[b] - RCD_W'(1);

            if (w_rd_beat) begin
                ddr3_dq_o[0] <= r_rd_word[{w_rd_off[1:0], 1'b0}];
                ddr3_dq_o[1] <= r_rd_word[{w_rd_off[1:0], 1'b1}];
                dq_valid_o   <= 1'b1;
            end else begin
                ddr3_dq_o  <= '0;
                dq_valid_o <= 1'b0;
            end
            if (r_rd_busy) r_rd_cnt <= r_rd_cnt + CW'(1);
            if (w_rd_done) begin
                r_rd_busy <= 1'b0;
                if (r_rd_ap) r_open[r_rd_bank] <= 1'b0;
            end

            if (w_wr_beat) begin
                r_wr_data <= w_wr_full;
                r_wr_dm   <= w_wr_fdm;
            end
            if (r_wr_busy) r_wr_cnt <= r_wr_cnt + CW'(1);
            if (w_wr_done) begin
                r_wr_busy <= 1'b0;
                if (r_wr_ap) r_open[r_wr_bank] <= 1'b0;
            end

            if (w_cmd_ok) begin
                if (w_act) begin
                    r_open[ddr3_ba_i] <= 1'b1;
                    r_row[ddr3_ba_i]  <= ddr3_addr_i[MEM_ROW_BITS-1:0];
                    r_rcd[ddr3_ba_i]  <= RCD_W'(T_RCD - 1);
                end
                if (w_pre) begin
                    if (ddr3_addr_i[10]) r_open <= '0;
                    else                 r_open[ddr3_ba_i] <= 1'b0;
                end
                if (w_mrs && (ddr3_ba_i == '0))           r_cl  <= {2'b00, ddr3_addr_i[6:4]} + CW'(4);
                if (w_mrs && (ddr3_ba_i == BANK_BITS'(2))) r_cwl <= {2'b00, ddr3_addr_i[5:3]} + CW'(5);
                if (w_rd) begin
                    r_rd_busy <= 1'b1;
                    r_rd_cnt  <= CW'(1);
                    r_rd_cl   <= r_cl;
                    r_rd_bank <= ddr3_ba_i;
                    r_rd_ap   <= ddr3_addr_i[10];
                    r_rd_word <= r_mem[w_idx];
                end
                if (w_wr) begin
                    r_wr_busy <= 1'b1;
                    r_wr_cnt  <= CW'(1);
                    r_wr_cwl  <= r_cwl;
                    r_wr_bank <= ddr3_ba_i;
                    r_wr_ap   <= ddr3_addr_i[10];
                    r_wr_idx  <= w_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_sddr_dev_model.sv
// Directed bench for sddr_dev_model: commands are driven on the falling edge, outputs checked there.
module tb_sddr_dev_model;
    logic clk = 1'b0, rst_n = 1'b0, cke = 1'b1;
    logic cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [2:0]       ba = '0;
    logic [13:0]      addr = '0;
    logic [1:0]       dm = '0;
    logic             dq_en = 1'b0;
    logic [1:0][15:0] dq_i = '0;
    logic [1:0][15:0] dq_o;
    logic             dq_valid, err;
    logic [3:0]       err_code;
    int n_checks = 0, n_fail = 0;

    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;

    always #5 clk = ~clk;

    sddr_dev_model dut (
        .ddr_clock_i(clk), .ddr_reset_n_i(rst_n), .ddr3_cke_i(cke),
        .ddr3_cs_n_i(cs_n), .ddr3_ras_n_i(ras_n), .ddr3_cas_n_i(cas_n), .ddr3_we_n_i(we_n),
        .ddr3_ba_i(ba), .ddr3_addr_i(addr), .ddr3_dm_i(dm), .ddr3_dq_enable_i(dq_en),
        .ddr3_dq_i(dq_i), .ddr3_dq_o(dq_o), .dq_valid_o(dq_valid),
        .err_o(err), .err_code_o(err_code)
    );

    // Command is sampled on the rising edge between the two falling edges.
    task automatic issue(input logic [3:0] c, input logic [2:0] b, input logic [13:0] a);
        {cs_n, ras_n, cas_n, we_n} = c; ba = b; addr = a;
        @(negedge clk);
        {cs_n, ras_n, cas_n, we_n} = C_NOP; ba = '0; addr = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_burst(input logic [2:0] b, input logic [13:0] a, input logic [7:0][15:0] d,
                               input logic [1:0] m, input int cwl);
        issue(C_WR, b, a);
        for (int k = 1; k <= cwl + 3; k++) begin
            if (k >= cwl) begin
                dq_i[0] = d[2*(k-cwl)]; dq_i[1] = d[2*(k-cwl)+1]; dm = m; dq_en = 1'b1;
            end
            @(negedge clk);
        end
        dq_en = 1'b0; dq_i = '0; dm = '0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++; if (dq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", dq_valid); end
        n_checks++; if (dq_o !== 32'h0) begin n_fail++; $display("FAIL reset_dq got %h exp 0", dq_o); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
        n_checks++; if (err_code !== 4'd0) begin n_fail++; $display("FAIL reset_code got %0d exp 0", err_code); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0][15:0] d;
        logic ev;
        for (int i = 0; i < 8; i++) d[i] = 16'(16'h1111 * (i + 1));
        issue(C_MRS, 3'd0, 14'h0020);
        issue(C_MRS, 3'd2, 14'h0008);
        issue(C_ACT, 3'd1, 14'd3);
        idle(4);
        write_burst(3'd1, 14'h010, d, 2'b00, 6);
        issue(C_RD, 3'd1, 14'h010);
        for (int k = 1; k <= 12; k++) begin
            ev = (k >= 6 && k <= 9);
            n_checks++; if (dq_valid !== ev) begin n_fail++; $display("FAIL basic_valid k=%0d got %b exp %b", k, dq_valid, ev); end
            if (ev) begin
                n_checks++; if (dq_o[0] !== d[2*(k-6)]) begin n_fail++; $display("FAIL basic_even k=%0d got %h exp %h", k, dq_o[0], d[2*(k-6)]); end
                n_checks++; if (dq_o[1] !== d[2*(k-6)+1]) begin n_fail++; $display("FAIL basic_odd k=%0d got %h exp %h", k, dq_o[1], d[2*(k-6)+1]); end
            end else begin
                n_checks++; if (dq_o !== 32'h0) begin n_fail++; $display("FAIL basic_idle_dq k=%0d got %h exp 0", k, dq_o); end
            end
            @(negedge clk);
        end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b code %0d exp 0", err, err_code); end
    endtask

    task automatic test_mask;
        logic [7:0][15:0] ones, d;
        for (int i = 0; i < 8; i++) begin
            ones[i] = 16'hFFFF;
            d[i] = 16'(16'h5510 + i);
        end
        write_burst(3'd1, 14'h020, ones, 2'b00, 6);
        write_burst(3'd1, 14'h020, d, 2'b10, 6);
        issue(C_RD, 3'd1, 14'h020);
        for (int k = 1; k <= 10; k++) begin
            if (k >= 6 && k <= 9) begin
                n_checks++; if (dq_o[0] !== 16'(16'hFF10 + 2*(k-6))) begin n_fail++; $display("FAIL mask_even k=%0d got %h exp %h", k, dq_o[0], 16'(16'hFF10 + 2*(k-6))); end
                n_checks++; if (dq_o[1] !== 16'(16'hFF11 + 2*(k-6))) begin n_fail++; $display("FAIL mask_odd k=%0d got %h exp %h", k, dq_o[1], 16'(16'hFF11 + 2*(k-6))); end
            end
            @(negedge clk);
        end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mask_err got %b code %0d exp 0", err, err_code); end
    endtask

    task automatic test_autoprecharge;
        issue(C_RD, 3'd1, 14'h0410);
        idle(9);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ap_first_err got %b exp 0", err); end
        issue(C_RD, 3'd1, 14'h010);
        for (int k = 1; k <= 12; k++) begin
            n_checks++; if (dq_valid !== 1'b0) begin n_fail++; $display("FAIL ap_valid k=%0d got %b exp 0", k, dq_valid); end
            @(negedge clk);
        end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ap_err got %b exp 1", err); end
        n_checks++; if (err_code !== 4'd2) begin n_fail++; $display("FAIL ap_code got %0d exp 2", err_code); end
    endtask

    task automatic test_trcd;
        do_reset;
        issue(C_ACT, 3'd2, 14'd0);
        idle(1);
        issue(C_RD, 3'd2, 14'd0);
        n_checks++; if (err_code !== 4'd3) begin n_fail++; $display("FAIL trcd_code got %0d exp 3", err_code); end
        for (int k = 2; k <= 9; k++) begin
            n_checks++; if (dq_valid !== 1'b0) begin n_fail++; $display("FAIL trcd_valid k=%0d got %b exp 0", k, dq_valid); end
            @(negedge clk);
        end
        issue(C_ACT, 3'd2, 14'd5);
        n_checks++; if (err_code !== 4'd3) begin n_fail++; $display("FAIL trcd_sticky got %0d exp 3", err_code); end
    endtask

    task automatic test_ref;
        do_reset;
        issue(C_ACT, 3'd5, 14'd0);
        issue(C_PRE, 3'd0, 14'h0400);
        issue(C_REF, 3'd0, 14'd0);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ref_preall_err got %b code %0d exp 0", err, err_code); end
        issue(C_ACT, 3'd0, 14'd0);
        issue(C_REF, 3'd0, 14'd0);
        n_checks++; if (err_code !== 4'd4) begin n_fail++; $display("FAIL ref_code got %0d exp 4", err_code); end
        issue(C_PRE, 3'd0, 14'h0400);
        issue(C_REF, 3'd0, 14'd0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ref_err_kept got %b exp 1", err); end
        n_checks++; if (err_code !== 4'd4) begin n_fail++; $display("FAIL ref_code_kept got %0d exp 4", err_code); end
        do_reset;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ref_reset_err got %b exp 0", err); end
    endtask

    task automatic test_back_to_back;
        logic ev;
        do_reset;
        issue(C_ACT, 3'd1, 14'd3);
        idle(4);
        issue(C_RD, 3'd1, 14'h010);
        for (int k = 1; k <= 12; k++) begin
            ev = (k >= 5 && k <= 8);
            n_checks++; if (dq_valid !== ev) begin n_fail++; $display("FAIL b2b_valid k=%0d got %b exp %b", k, dq_valid, ev); end
            if (k == 5) begin
                n_checks++; if (dq_o[0] !== 16'h1111) begin n_fail++; $display("FAIL b2b_beat0 got %h exp 1111", dq_o[0]); end
            end
            if (k == 2) {cs_n, ras_n, cas_n, we_n} = C_RD;
            if (k == 2) ba = 3'd1;
            @(negedge clk);
            {cs_n, ras_n, cas_n, we_n} = C_NOP; ba = '0;
        end
        n_checks++; if (err_code !== 4'd5) begin n_fail++; $display("FAIL b2b_code got %0d exp 5", err_code); end
        do_reset;
        issue(C_ACT, 3'd1, 14'd3);
        idle(4);
        issue(C_RD, 3'd1, 14'h010);
        idle(4);
        n_checks++; if (dq_valid !== 1'b1) begin n_fail++; $display("FAIL async_pre_valid got %b exp 1", dq_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (dq_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got %b exp 0", dq_valid); end
        n_checks++; if (dq_o !== 32'h0) begin n_fail++; $display("FAIL async_dq got %h exp 0", dq_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_basic;
        test_mask;
        test_autoprecharge;
        test_trcd;
        test_ref;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
